// File: rtl/fsk_frame_rx.sv
// Framed FSK receiver: counts line transitions per symbol window to decide bits,
// hunts for a sync byte, then assembles the following payload bits into a word.
module fsk_frame_rx #(
  parameter int                SYM_LEN = 16,
  parameter int                THRESH  = 12,
  parameter int                LOSS_TH = 4,
  parameter int                SYNC_W  = 8,
  parameter logic [SYNC_W-1:0] SYNC    = 8'hD5,
  parameter int                WORD_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fsk_in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked,
  output logic              carrier
);

  localparam int SW  = $clog2(SYM_LEN);
  localparam int CW  = $clog2(SYM_LEN) + 1;
  localparam int BCW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, HUNT, PAYLOAD} state_t;

  state_t              state_q, state_d;
  logic                fsk_q;
  logic [SW-1:0]       sym_cnt_q, sym_cnt_d;
  logic [CW-1:0]       edge_cnt_q, edge_cnt_d;
  logic [SYNC_W-1:0]   sync_sr_q, sync_sr_d;
  logic [WORD_W-1:0]   data_sr_q, data_sr_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                bit_out_q, bit_out_d;
  logic                bit_valid_q, bit_valid_d;
  logic [WORD_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                edge_w;
  logic                dec_bit;
  logic [CW-1:0]       total;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic e);
    if (e && (c < CW'(SYM_LEN))) return c + 1'b1;
    return c;
  endfunction

  always_comb begin
    edge_w       = fsk_in ^ fsk_q;
    total        = edge_cnt_q + {{(CW-1){1'b0}}, edge_w};
    dec_bit      = (total >= CW'(THRESH));
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    sync_sr_d    = sync_sr_q;
    data_sr_d    = data_sr_q;
    bit_cnt_d    = bit_cnt_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        sym_cnt_d  = '0;
        edge_cnt_d = '0;
        // The edge that wakes us up is sample 0 of the first window.
        if (edge_w) begin
          state_d    = HUNT;
          sym_cnt_d  = SW'(1);
          edge_cnt_d = CW'(1);
        end
      end
      default: begin
        if (sym_cnt_q == SW'(SYM_LEN - 1)) begin
          sym_cnt_d  = '0;
          edge_cnt_d = '0;
          if (total < CW'(LOSS_TH)) begin
            state_d   = IDLE;
            sync_sr_d = '0;
            data_sr_d = '0;
            bit_cnt_d = '0;
          end else begin
            bit_out_d   = dec_bit;
            bit_valid_d = 1'b1;
            if (state_q == HUNT) begin
              sync_sr_d = {sync_sr_q[SYNC_W-2:0], dec_bit};
              if (sync_sr_d == SYNC) begin
                state_d   = PAYLOAD;
                bit_cnt_d = '0;
                data_sr_d = '0;
              end
            end else begin
              data_sr_d = {data_sr_q[WORD_W-2:0], dec_bit};
              bit_cnt_d = bit_cnt_q + 1'b1;
              // Each frame needs a fresh full sync, so the hunt history is wiped.
              if (bit_cnt_q == BCW'(WORD_W - 1)) begin
                data_out_d   = data_sr_d;
                data_valid_d = 1'b1;
                state_d      = HUNT;
                sync_sr_d    = '0;
                bit_cnt_d    = '0;
              end
            end
          end
        end else begin
          sym_cnt_d  = sym_cnt_q + 1'b1;
          edge_cnt_d = sat_inc(edge_cnt_q, edge_w);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fsk_q        <= 1'b0;
      sym_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      sync_sr_q    <= '0;
      data_sr_q    <= '0;
      bit_cnt_q    <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fsk_q        <= fsk_in;
      sym_cnt_q    <= sym_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      sync_sr_q    <= sync_sr_d;
      data_sr_q    <= data_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = (state_q == PAYLOAD);
  assign carrier    = (state_q != IDLE);

endmodule

// File: tb/tb_fsk_frame_rx.sv
// Bench for fsk_frame_rx: windows described by their edge counts, expected bit and
// word events derived from the framing rules, compared against logged DUT strobes.
module tb_fsk_frame_rx;
  localparam int SYM_LEN = 16;
  localparam int THRESH  = 12;
  localparam int LOSS_TH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fsk_in;
  logic        bit_out, bit_valid, data_valid, locked, carrier;
  logic [15:0] data_out;

  int nasrt = 0;
  int nfail = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsk_frame_rx dut (
    .clk       (clk),
    .rst       (rst),
    .fsk_in    (fsk_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .data_out  (data_out),
    .data_valid(data_valid),
    .locked    (locked),
    .carrier   (carrier)
  );

  // Observed strobes
  int          bv_cyc[$];
  logic        bv_val[$];
  logic        bv_lock[$];
  int          dv_cyc[$];
  logic [15:0] dv_word[$];

  // Expected strobes and stimulus
  int          eb_cyc[$];
  logic        eb_val[$];
  logic        eb_lock[$];
  int          ed_cyc[$];
  logic [15:0] ed_word[$];
  int          win[$];
  logic [15:0] last_word = 16'h0000;

  always @(negedge clk) begin
    if (bit_valid === 1'b1) begin
      bv_cyc.push_back(cyc);
      bv_val.push_back(bit_out);
      bv_lock.push_back(locked);
    end
    if (data_valid === 1'b1) begin
      dv_cyc.push_back(cyc);
      dv_word.push_back(data_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    bv_cyc.delete(); bv_val.delete(); bv_lock.delete();
    dv_cyc.delete(); dv_word.delete();
    eb_cyc.delete(); eb_val.delete(); eb_lock.delete();
    ed_cyc.delete(); ed_word.delete();
  endtask

  // Append symbols MSB first; random mode picks any count that still decodes the same.
  task automatic add_bits(input logic [31:0] v, input int nbits, input bit rnd);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (v[i]) win.push_back(rnd ? int'($urandom_range(16, THRESH)) : 16);
      else      win.push_back(rnd ? int'($urandom_range(THRESH - 1, LOSS_TH)) : 8);
    end
  endtask

  // n toggles spread over the window, always including its first cycle.
  task automatic drive_window(input int n);
    for (int i = 0; i < SYM_LEN; i++) begin
      if (((i * n) % SYM_LEN) < n) fsk_in = ~fsk_in;
      @(negedge clk);
    end
  endtask

  // Framing rules applied window by window; p0 is the cycle of the first window sample.
  task automatic model_burst(input int p0);
    int  hist = 0;
    int  word = 0;
    int  nb   = 0;
    bit  pay  = 1'b0;
    bit  b;
    int  t;
    for (int k = 0; k < win.size(); k++) begin
      if (win[k] < LOSS_TH) break;
      b = (win[k] >= THRESH);
      t = p0 + SYM_LEN - 1 + SYM_LEN * k;
      if (pay) begin
        word = ((word * 2) + int'(b)) % 65536;
        nb++;
        if (nb == 16) begin
          ed_cyc.push_back(t);
          ed_word.push_back(16'(word));
          last_word = 16'(word);
          pay  = 1'b0;
          hist = 0;
        end
      end else begin
        hist = ((hist * 2) + int'(b)) % 256;
        if (hist == 'hD5) begin
          pay  = 1'b1;
          nb   = 0;
          word = 0;
        end
      end
      eb_cyc.push_back(t);
      eb_val.push_back(b);
      eb_lock.push_back(pay);
    end
  endtask

  task automatic drive_all(output int p0);
    @(negedge clk);
    p0 = cyc + 1;
    model_burst(p0);
    for (int k = 0; k < win.size(); k++) drive_window(win[k]);
  endtask

  task automatic compare_logs(input string tag);
    chk({tag, "_bit_count"}, bv_cyc.size(), eb_cyc.size());
    for (int k = 0; k < eb_cyc.size() && k < bv_cyc.size(); k++) begin
      chk({tag, "_bit_cycle"}, bv_cyc[k], eb_cyc[k]);
      chk({tag, "_bit_value"}, bv_val[k], eb_val[k]);
      chk({tag, "_bit_locked"}, bv_lock[k], eb_lock[k]);
    end
    chk({tag, "_word_count"}, dv_cyc.size(), ed_cyc.size());
    for (int k = 0; k < ed_cyc.size() && k < dv_cyc.size(); k++) begin
      chk({tag, "_word_cycle"}, dv_cyc[k], ed_cyc[k]);
      chk({tag, "_word_value"}, dv_word[k], ed_word[k]);
    end
  endtask

  task automatic run_burst(input string tag);
    int p0;
    clear_logs();
    drive_all(p0);
    repeat (2 * SYM_LEN + 4) @(negedge clk);
    compare_logs(tag);
    chk({tag, "_carrier_after"}, carrier, 1'b0);
    chk({tag, "_locked_after"}, locked, 1'b0);
    chk({tag, "_data_hold"}, data_out, last_word);
    win.delete();
  endtask

  initial begin
    int p0;
    rst    = 1'b1;
    fsk_in = 1'b0;

    // Reset while the line toggles
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      fsk_in = ~fsk_in;
      @(negedge clk);
      chk("rst_bit_valid", bit_valid, 1'b0);
      chk("rst_data_valid", data_valid, 1'b0);
      chk("rst_carrier", carrier, 1'b0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_bit_out", bit_out, 1'b0);
      chk("rst_data_out", data_out, 16'h0000);
    end
    fsk_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (50) @(negedge clk);
    chk("idle_carrier", carrier, 1'b0);
    chk("idle_no_bits", bv_cyc.size(), 0);

    // Nominal frame
    add_bits(32'hD5, 8, 1'b0);
    add_bits(32'h1234, 16, 1'b0);
    run_burst("frame_1234");

    // Noise before sync, then a payload holding the sync pattern
    add_bits(32'h5, 3, 1'b0);
    add_bits(32'hD5, 8, 1'b0);
    add_bits(32'hFFFF, 16, 1'b0);
    add_bits(32'hD5, 8, 1'b0);
    add_bits(32'h00D5, 16, 1'b0);
    run_burst("slide_ffff_00d5");

    // Threshold boundaries and loss
    win.push_back(12); win.push_back(11); win.push_back(4);
    win.push_back(12); win.push_back(3);
    run_burst("thresholds");

    // Carrier drops halfway through the payload, then a clean frame
    add_bits(32'hD5, 8, 1'b0);
    add_bits(32'hC3, 8, 1'b0);
    run_burst("drop_midword");
    add_bits(32'hD5, 8, 1'b0);
    add_bits(32'hBEEF, 16, 1'b0);
    run_burst("frame_beef");

    // Reset pulse mid-payload
    clear_logs();
    add_bits(32'hD5, 8, 1'b0);
    add_bits(32'h15, 5, 1'b0);
    drive_all(p0);
    rst    = 1'b1;
    fsk_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_bit_valid", bit_valid, 1'b0);
    chk("midrst_data_valid", data_valid, 1'b0);
    chk("midrst_carrier", carrier, 1'b0);
    chk("midrst_locked", locked, 1'b0);
    chk("midrst_bit_out", bit_out, 1'b0);
    chk("midrst_data_out", data_out, 16'h0000);
    repeat (40) @(negedge clk);
    chk("midrst_no_word", dv_cyc.size(), 0);
    chk("midrst_carrier_after", carrier, 1'b0);
    win.delete();
    last_word = 16'h0000;
    add_bits(32'hD5, 8, 1'b0);
    add_bits(32'hA5A5, 16, 1'b0);
    run_burst("frame_a5a5");

    // Randomised edge counts and payloads
    for (int r = 0; r < 3; r++) begin
      add_bits($urandom, 3, 1'b1);
      add_bits(32'hD5, 8, 1'b1);
      add_bits($urandom, 16, 1'b1);
      add_bits(32'hD5, 8, 1'b1);
      add_bits($urandom, 16, 1'b1);
      run_burst("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
